// File: rtl/ysyx_24100012_lsu_pkg.sv
// Shared types and constants for the ysyx_24100012 load/store unit.
package ysyx_24100012_lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int WSTRB_W = 4;

  // Access size comes from funct3[1:0]: 00 byte, 01 half, anything else word.
  function automatic logic lsu_misaligned(input logic [2:0] sel, input logic [1:0] off);
    logic r_mis;
    case (sel[1:0])
      2'b00:   r_mis = 1'b0;
      2'b01:   r_mis = off[0];
      default: r_mis = (off != 2'b00);
    endcase
    return r_mis;
  endfunction

endpackage

// File: rtl/ysyx_24100012_lsu_if.sv
// Request, memory-bus and response signals of the LSU; master is the LSU side.
interface ysyx_24100012_lsu_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  import ysyx_24100012_lsu_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic                  in_wen;
  logic [2:0]            in_sel;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic [DATA_WIDTH-1:0] in_wdata;

  logic                  bus_req;
  logic                  bus_gnt;
  logic                  bus_we;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [DATA_WIDTH-1:0] bus_wdata;
  logic [WSTRB_W-1:0]    bus_wstrb;
  logic                  bus_rvalid;
  logic [DATA_WIDTH-1:0] bus_rdata;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_err;

  modport master (
    input  in_valid, in_wen, in_sel, in_addr, in_wdata,
    output in_ready,
    output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    input  bus_gnt, bus_rvalid, bus_rdata,
    output out_valid, out_data, out_err,
    input  out_ready
  );

  modport slave (
    output in_valid, in_wen, in_sel, in_addr, in_wdata,
    input  in_ready,
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    output bus_gnt, bus_rvalid, bus_rdata,
    input  out_valid, out_data, out_err,
    output out_ready
  );

endinterface

// File: rtl/ysyx_24100012_lsu_align.sv
// Store lane replication/strobe generation and load byte extraction/extension.
module ysyx_24100012_lsu_align
  import ysyx_24100012_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            i_sel,
  input  logic [1:0]            i_off,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  output logic [WSTRB_W-1:0]    o_wstrb,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] w_sh;
  logic                  w_sext;

  assign w_sh   = i_rdata >> {i_off, 3'b000};
  assign w_sext = ~i_sel[2];

  always_comb begin
    o_wstrb = 4'b1111;
    o_wdata = i_wdata;
    o_rdata = w_sh;
    case (i_sel[1:0])
      2'b00: begin
        o_wstrb = 4'b0001 << i_off;
        o_wdata = {(DATA_WIDTH/8){i_wdata[7:0]}};
        o_rdata = {{(DATA_WIDTH-8){w_sext & w_sh[7]}}, w_sh[7:0]};
      end
      2'b01: begin
        // Strobe bits shifted past lane 3 fall off the 4-bit result.
        o_wstrb = 4'b0011 << i_off;
        o_wdata = {(DATA_WIDTH/16){i_wdata[15:0]}};
        o_rdata = {{(DATA_WIDTH-16){w_sext & w_sh[15]}}, w_sh[15:0]};
      end
      default: begin
        o_wstrb = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = w_sh;
      end
    endcase
  end

endmodule

// File: rtl/ysyx_24100012_lsu.sv
// ysyx_24100012 LSU: IDLE->REQ->WAIT->DONE bus sequencer with registered handshake outputs.
// Define YSYX_24100012_LSU_MISALIGN_CHK_EN to fault misaligned h/w accesses without a bus cycle.
module ysyx_24100012_lsu
  import ysyx_24100012_lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic                  clk,
  input logic                  rst,
  ysyx_24100012_lsu_if.master  io
);

  lsu_state_e            r_state;
  logic                  r_in_ready;
  logic                  r_bus_req;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_wen;
  logic [2:0]            r_sel;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
`ifdef YSYX_24100012_LSU_MISALIGN_CHK_EN
  logic                  r_out_err;
`endif

  logic [WSTRB_W-1:0]    w_wstrb;
  logic [DATA_WIDTH-1:0] w_bus_wdata;
  logic [DATA_WIDTH-1:0] w_load_data;

  ysyx_24100012_lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .i_sel   (r_sel),
    .i_off   (r_addr[1:0]),
    .i_wdata (r_wdata),
    .i_rdata (io.bus_rdata),
    .o_wstrb (w_wstrb),
    .o_wdata (w_bus_wdata),
    .o_rdata (w_load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_bus_req   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_wen       <= 1'b0;
      r_sel       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
`ifdef YSYX_24100012_LSU_MISALIGN_CHK_EN
      r_out_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io.in_valid) begin
            r_wen      <= io.in_wen;
            r_sel      <= io.in_sel;
            r_addr     <= io.in_addr;
            r_wdata    <= io.in_wdata;
            r_in_ready <= 1'b0;
`ifdef YSYX_24100012_LSU_MISALIGN_CHK_EN
            if (lsu_misaligned(io.in_sel, io.in_addr[1:0])) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_out_err   <= 1'b1;
              r_out_data  <= '0;
            end else begin
              r_state   <= S_REQ;
              r_bus_req <= 1'b1;
            end
`else
            r_state   <= S_REQ;
            r_bus_req <= 1'b1;
`endif
          end
        end
        S_REQ: begin
          if (io.bus_gnt) begin
            r_state   <= S_WAIT;
            r_bus_req <= 1'b0;
          end
        end
        S_WAIT: begin
          if (io.bus_rvalid) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_out_data  <= r_wen ? '0 : w_load_data;
          end
        end
        S_DONE: begin
          if (io.out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
`ifdef YSYX_24100012_LSU_MISALIGN_CHK_EN
            r_out_err   <= 1'b0;
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io.in_ready  = r_in_ready;
  assign io.bus_req   = r_bus_req;
  assign io.bus_we    = r_wen;
  assign io.bus_addr  = {r_addr[ADDR_WIDTH-1:2], 2'b00};
  assign io.bus_wdata = w_bus_wdata;
  assign io.bus_wstrb = w_wstrb;
  assign io.out_valid = r_out_valid;
  assign io.out_data  = r_out_data;
`ifdef YSYX_24100012_LSU_MISALIGN_CHK_EN
  assign io.out_err   = r_out_err;
`else
  assign io.out_err   = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_24100012_lsu.sv
// Directed table-driven bench for ysyx_24100012_lsu plus stall, reset and misalignment sequences.
module tb_ysyx_24100012_lsu;

  typedef struct {
    string       name;
    logic        wen;
    logic [2:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_data;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;

  ysyx_24100012_lsu_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) lsu_if ();

  ysyx_24100012_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .io  (lsu_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v);
    lsu_if.in_valid = 1'b1;
    lsu_if.in_wen   = v.wen;
    lsu_if.in_sel   = v.sel;
    lsu_if.in_addr  = v.addr;
    lsu_if.in_wdata = v.wdata;
    chk({v.name, "/in_ready0"}, 32'(lsu_if.in_ready), 32'd1);
    step();
    lsu_if.in_valid = 1'b0;
    chk({v.name, "/bus_req"}, 32'(lsu_if.bus_req), 32'd1);
    chk({v.name, "/bus_addr"}, lsu_if.bus_addr, v.exp_addr);
    chk({v.name, "/bus_we"}, 32'(lsu_if.bus_we), 32'(v.wen));
    if (v.wen) begin
      chk({v.name, "/bus_wstrb"}, 32'(lsu_if.bus_wstrb), 32'(v.exp_wstrb));
      chk({v.name, "/bus_wdata"}, lsu_if.bus_wdata, v.exp_wdata);
    end
    lsu_if.bus_gnt = 1'b1;
    step();
    lsu_if.bus_gnt = 1'b0;
    chk({v.name, "/bus_req_drop"}, 32'(lsu_if.bus_req), 32'd0);
    lsu_if.bus_rvalid = 1'b1;
    lsu_if.bus_rdata  = v.rdata;
    step();
    lsu_if.bus_rvalid = 1'b0;
    chk({v.name, "/out_valid"}, 32'(lsu_if.out_valid), 32'd1);
    chk({v.name, "/out_data"}, lsu_if.out_data, v.exp_data);
    chk({v.name, "/out_err"}, 32'(lsu_if.out_err), 32'd0);
    lsu_if.out_ready = 1'b1;
    step();
    lsu_if.out_ready = 1'b0;
    chk({v.name, "/out_valid_clr"}, 32'(lsu_if.out_valid), 32'd0);
    chk({v.name, "/in_ready1"}, 32'(lsu_if.in_ready), 32'd1);
  endtask

  vec_t        vecs[12];
  vec_t        xv;
  logic [31:0] hold_addr;
  logic [31:0] hold_data;

  initial begin
    n_checks = 0;
    n_err    = 0;

    vecs[0]  = '{"lb_off3",   1'b0, 3'b000, 32'h8000_0003, 32'h0,         32'h80AB_CDEF, 32'h8000_0000, 4'h0,    32'h0,         32'hFFFF_FF80};
    vecs[1]  = '{"lhu_off2",  1'b0, 3'b101, 32'h8000_0002, 32'h0,         32'h9234_5678, 32'h8000_0000, 4'h0,    32'h0,         32'h0000_9234};
    vecs[2]  = '{"lh_off2",   1'b0, 3'b001, 32'h8000_0002, 32'h0,         32'h9234_5678, 32'h8000_0000, 4'h0,    32'h0,         32'hFFFF_9234};
    vecs[3]  = '{"sb_off1",   1'b1, 3'b000, 32'h8000_0001, 32'h1122_33A5, 32'hFFFF_FFFF, 32'h8000_0000, 4'b0010, 32'hA5A5_A5A5, 32'h0};
    vecs[4]  = '{"lbu_off1",  1'b0, 3'b100, 32'h8000_0001, 32'h0,         32'h1234_5678, 32'h8000_0000, 4'h0,    32'h0,         32'h0000_0056};
    vecs[5]  = '{"lw_off0",   1'b0, 3'b010, 32'h8000_0010, 32'h0,         32'hDEAD_BEEF, 32'h8000_0010, 4'h0,    32'h0,         32'hDEAD_BEEF};
    vecs[6]  = '{"sh_off2",   1'b1, 3'b001, 32'h8000_0002, 32'hAAAA_1234, 32'hFFFF_FFFF, 32'h8000_0000, 4'b1100, 32'h1234_1234, 32'h0};
    vecs[7]  = '{"sw_off0",   1'b1, 3'b010, 32'h8000_0004, 32'hCAFE_F00D, 32'h1234_5678, 32'h8000_0004, 4'b1111, 32'hCAFE_F00D, 32'h0};
    vecs[8]  = '{"sel011_w",  1'b0, 3'b011, 32'h8000_0008, 32'h0,         32'h8765_4321, 32'h8000_0008, 4'h0,    32'h0,         32'h8765_4321};
    vecs[9]  = '{"sel110_w",  1'b0, 3'b110, 32'h8000_000C, 32'h0,         32'h0102_0304, 32'h8000_000C, 4'h0,    32'h0,         32'h0102_0304};
    vecs[10] = '{"lb_pos",    1'b0, 3'b000, 32'h8000_0000, 32'h0,         32'h0000_007F, 32'h8000_0000, 4'h0,    32'h0,         32'h0000_007F};
    vecs[11] = '{"lh_neg",    1'b0, 3'b001, 32'h8000_0000, 32'h0,         32'h0000_8001, 32'h8000_0000, 4'h0,    32'h0,         32'hFFFF_8001};

    lsu_if.in_valid   = 1'b0;
    lsu_if.in_wen     = 1'b0;
    lsu_if.in_sel     = 3'b000;
    lsu_if.in_addr    = 32'h0;
    lsu_if.in_wdata   = 32'h0;
    lsu_if.bus_gnt    = 1'b0;
    lsu_if.bus_rvalid = 1'b0;
    lsu_if.bus_rdata  = 32'h0;
    lsu_if.out_ready  = 1'b0;

    rst = 1'b1;
    #12;
    chk("rst/in_ready", 32'(lsu_if.in_ready), 32'd1);
    chk("rst/bus_req", 32'(lsu_if.bus_req), 32'd0);
    chk("rst/out_valid", 32'(lsu_if.out_valid), 32'd0);
    chk("rst/out_err", 32'(lsu_if.out_err), 32'd0);
    chk("rst/out_data", lsu_if.out_data, 32'h0);
    step();
    rst = 1'b0;
    step();

    for (int i = 0; i < 12; i++) run_txn(vecs[i]);

    // Grant stall, rvalid in REQ ignored, DONE backpressure, no accept on release cycle.
    lsu_if.in_valid = 1'b1;
    lsu_if.in_wen   = 1'b0;
    lsu_if.in_sel   = 3'b010;
    lsu_if.in_addr  = 32'h8000_0020;
    step();
    lsu_if.in_valid = 1'b0;
    hold_addr = lsu_if.bus_addr;
    chk("stall/addr0", hold_addr, 32'h8000_0020);
    for (int c = 0; c < 5; c++) begin
      lsu_if.bus_rvalid = (c == 2);
      lsu_if.bus_rdata  = 32'hBAD0_BAD0;
      step();
      chk("stall/bus_req", 32'(lsu_if.bus_req), 32'd1);
      chk("stall/bus_addr", lsu_if.bus_addr, hold_addr);
      chk("stall/in_ready", 32'(lsu_if.in_ready), 32'd0);
      chk("stall/out_valid", 32'(lsu_if.out_valid), 32'd0);
    end
    lsu_if.bus_rvalid = 1'b0;
    lsu_if.bus_gnt = 1'b1;
    step();
    lsu_if.bus_gnt = 1'b0;
    lsu_if.bus_rvalid = 1'b1;
    lsu_if.bus_rdata  = 32'h1357_9BDF;
    step();
    lsu_if.bus_rvalid = 1'b0;
    lsu_if.bus_rdata  = 32'h0;
    hold_data = 32'h1357_9BDF;
    for (int c = 0; c < 3; c++) begin
      chk("bp/out_valid", 32'(lsu_if.out_valid), 32'd1);
      chk("bp/out_data", lsu_if.out_data, hold_data);
      chk("bp/in_ready", 32'(lsu_if.in_ready), 32'd0);
      step();
    end
    lsu_if.out_ready = 1'b1;
    lsu_if.in_valid  = 1'b1;
    lsu_if.in_addr   = 32'h8000_0040;
    step();
    lsu_if.out_ready = 1'b0;
    lsu_if.in_valid  = 1'b0;
    chk("bp/release_in_ready", 32'(lsu_if.in_ready), 32'd1);
    chk("bp/release_no_req", 32'(lsu_if.bus_req), 32'd0);
    chk("bp/release_out_valid", 32'(lsu_if.out_valid), 32'd0);
    step();
    chk("bp/idle_no_req", 32'(lsu_if.bus_req), 32'd0);

    // Reset while waiting for read data; the late rvalid must not produce a response.
    lsu_if.in_valid = 1'b1;
    lsu_if.in_sel   = 3'b010;
    lsu_if.in_addr  = 32'h8000_0050;
    step();
    lsu_if.in_valid = 1'b0;
    lsu_if.bus_gnt  = 1'b1;
    step();
    lsu_if.bus_gnt  = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst/in_ready", 32'(lsu_if.in_ready), 32'd1);
    chk("mid_rst/bus_req", 32'(lsu_if.bus_req), 32'd0);
    step();
    rst = 1'b0;
    lsu_if.bus_rvalid = 1'b1;
    lsu_if.bus_rdata  = 32'h5555_AAAA;
    step();
    lsu_if.bus_rvalid = 1'b0;
    chk("mid_rst/out_valid", 32'(lsu_if.out_valid), 32'd0);
    chk("mid_rst/in_ready2", 32'(lsu_if.in_ready), 32'd1);
    step();
    chk("mid_rst/out_valid2", 32'(lsu_if.out_valid), 32'd0);
    chk("mid_rst/out_data", lsu_if.out_data, 32'h0);

`ifdef YSYX_24100012_LSU_MISALIGN_CHK_EN
    lsu_if.in_valid = 1'b1;
    lsu_if.in_wen   = 1'b0;
    lsu_if.in_sel   = 3'b010;
    lsu_if.in_addr  = 32'h8000_0002;
    step();
    lsu_if.in_valid = 1'b0;
    chk("mis/bus_req", 32'(lsu_if.bus_req), 32'd0);
    chk("mis/out_valid", 32'(lsu_if.out_valid), 32'd1);
    chk("mis/out_err", 32'(lsu_if.out_err), 32'd1);
    chk("mis/out_data", lsu_if.out_data, 32'h0);
    lsu_if.out_ready = 1'b1;
    step();
    lsu_if.out_ready = 1'b0;
    chk("mis/in_ready", 32'(lsu_if.in_ready), 32'd1);
    chk("mis/out_err_clr", 32'(lsu_if.out_err), 32'd0);
`else
    xv = '{"lw_mis_off2",  1'b0, 3'b010, 32'h8000_0002, 32'h0,         32'hAABB_CCDD, 32'h8000_0000, 4'h0,    32'h0,         32'h0000_AABB};
    run_txn(xv);
    xv = '{"sh_mis_off3",  1'b1, 3'b001, 32'h8000_0003, 32'h9999_5678, 32'h0,         32'h8000_0000, 4'b1000, 32'h5678_5678, 32'h0};
    run_txn(xv);
    xv = '{"lhu_mis_off3", 1'b0, 3'b101, 32'h8000_0003, 32'h0,         32'hAB00_0000, 32'h8000_0000, 4'h0,    32'h0,         32'h0000_00AB};
    run_txn(xv);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ysyx_24100012_lsu.md
YSYX_24100012_LSU -- requirements
Module: ysyx_24100012_lsu

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, 32, byte address width.
REQ-002 SHALL have parameter DATA_WIDTH, 32, bus and register data width.
REQ-003 SHALL have one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 in_valid  in  1  request from EXU; in_ready  out  1  LSU can accept.
REQ-006 in_wen  in  1  1=store, 0=load; in_sel  in  3  funct3 (000 b, 001 h, 010 w, 100 bu, 101 hu).
REQ-007 in_addr  in  ADDR_WIDTH  byte address; in_wdata  in  DATA_WIDTH  store data (rs2).
REQ-008 bus_req  out  1; bus_gnt  in  1; bus_we  out  1; bus_addr  out  ADDR_WIDTH  word-aligned address.
REQ-009 bus_wdata  out  DATA_WIDTH; bus_wstrb  out  4; bus_rvalid  in  1  read data or write ack; bus_rdata  in  DATA_WIDTH.
REQ-010 out_valid  out  1; out_ready  in  1; out_data  out  DATA_WIDTH  extended load result (0 for stores); out_err  out  1  misaligned fault.

Function
REQ-011 SHALL implement FSM IDLE, REQ, WAIT, DONE; in_ready=1 only in IDLE.
REQ-012 IDLE: on in_valid, SHALL register wen/sel/addr/wdata and go to REQ (or to DONE with out_err=1 per REQ-025).
REQ-013 REQ: bus_req=1 with stable bus_addr/we/wdata/wstrb; on bus_gnt SHALL go to WAIT; bus_rvalid in REQ SHALL be ignored.
REQ-014 WAIT: bus_req=0; on bus_rvalid SHALL register extracted load data (stores: 0) and go to DONE.
REQ-015 DONE: out_valid=1, out_data/out_err stable; on out_ready SHALL go to IDLE; no new request is accepted in that cycle.
REQ-016 Minimum latency: accept at cycle 0, gnt at cycle 1, rvalid at cycle 2 -> out_valid at cycle 3.
REQ-017 bus_addr SHALL be {addr[ADDR_WIDTH-1:2],2'b00}; off = addr[1:0].
REQ-018 Store strobe: b 4'b0001<<off, h 4'b0011<<off, w 4'b1111; bits shifted past bit 3 are dropped.
REQ-019 Store data: b {4{wdata[7:0]}}, h {2{wdata[15:0]}}, w wdata.
REQ-020 Load: SHALL shift bus_rdata right by 8*off (zero fill), then b/h sign-extend from bit 7/15, bu/hu zero-extend, w pass-through.
REQ-021 in_sel 011, 110, 111 SHALL be treated as w.
REQ-022 out_err SHALL be 0 whenever REQ-025 does not apply.

Reset
REQ-023 Reset SHALL force IDLE immediately: bus_req=0, out_valid=0, out_err=0, out_data=0, in_ready=1.
REQ-024 Reset mid-transaction SHALL abandon it; any bus_rvalid after reset, before a new request, SHALL be ignored.

Configuration
REQ-025 With YSYX_24100012_LSU_MISALIGN_CHK_EN defined: h/hu with addr[0]=1 or w with off!=0 SHALL skip the bus (IDLE->DONE next cycle), out_err=1, out_data=0.
REQ-026 Without the macro: no check, out_err tied 0, misaligned accesses issued per REQ-018/REQ-020.

Structure
REQ-027 Package ysyx_24100012_lsu_pkg SHALL hold the state enum, the funct3 width codes, and the WSTRB_W=4 constant.
REQ-028 Combinational store alignment and load extraction SHALL sit in sub-module ysyx_24100012_lsu_align; FSM and registers stay in the top.

Verification
REQ-029 lb, addr 0x8000_0003, rdata 0x80AB_CDEF, gnt/rvalid immediate -> bus_addr 0x8000_0000, out_data 0xFFFF_FF80 at cycle 3.
REQ-030 lhu, addr 0x8000_0002, rdata 0x9234_5678 -> out_data 0x0000_9234; lh same -> 0xFFFF_9234.
REQ-031 sb, addr 0x8000_0001, wdata 0x1122_33A5 -> bus_wstrb 4'b0010, bus_wdata 0xA5A5_A5A5, bus_we=1, out_data 0.
REQ-032 bus_gnt held low 5 cycles, out_ready low 3 cycles in DONE -> bus_req and out_valid/out_data held stable; in_ready=0 throughout.
REQ-033 rst asserted in WAIT, late bus_rvalid delivered after release -> state IDLE, out_valid stays 0.
REQ-034 lw at 0x8000_0002: with macro -> no bus_req, out_err=1 next cycle; without -> bus_wstrb n/a, out_data = rdata>>16.
